param_serializer: RTL

Parametrised parallel-to-serial converter, the next-generation serializer for the UART TX path.
- Captures a DATA_WIDTH-bit word and shifts it out one bit per ser_en strobe, LSB- or MSB-first, selected per word.
- Handshakes with the upstream data source through ser_ready and with the TX frame FSM through ser_busy and ser_done.
- Supports back-to-back words with no idle cycle.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/param_serializer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX serializer path.
//   ser_state_t   : serializer FSM states (IDLE, ACTIVE)
//   SER_MAX_WIDTH : widest word any serializer instance may carry
//   clog2()       : ceiling log2 for flows without $clog2
package uart_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ser_state_t;

    localparam int SER_MAX_WIDTH = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/param_serializer.sv
// Parallel-to-serial converter for the UART TX path.
// Captures a DATA_WIDTH-bit word and shifts it out one bit per ser_en strobe,
// LSB- or MSB-first (chosen per word). Supports back-to-back words.
// Ports:
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   P_DATA     : parallel word, captured on an accepted load
//   Data_Valid : load request; accepted when Data_Valid && ser_ready
//   msb_first  : bit order captured with P_DATA (1 = MSB first)
//   ser_en     : advance strobe, one bit per cycle while high
//   ser_data   : current serial bit (registered)
//   ser_done   : high while the final bit is on ser_data (registered)
//   ser_busy   : high while ACTIVE (registered)
//   ser_ready  : combinational load-accept indication
module param_serializer
    import uart_pkg::*;
#(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_VAL   = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  msb_first,
    input  logic                  ser_en,
    output logic                  ser_data,
    output logic                  ser_done,
    output logic                  ser_busy,
    output logic                  ser_ready
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    // Compare against DATA_WIDTH-1 explicitly so non-power-of-two widths
    // stop at the right index instead of the counter's all-ones value.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    ser_state_t            state_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  msb_q;
    logic                  data_q;
    logic                  done_q;
    logic                  busy_q;

    logic                  last_bit;
    logic                  first_bit_d;
    logic [DATA_WIDTH-1:0] shreg_d;
    logic                  next_bit_d;
    logic [CNT_W-1:0]      cnt_d;

    assign last_bit    = (cnt_q == LAST_IDX);
    assign first_bit_d = msb_first ? P_DATA[DATA_WIDTH-1] : P_DATA[0];
    // The output end is bit DATA_WIDTH-1 for MSB-first words, bit 0 otherwise.
    assign shreg_d     = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
    assign next_bit_d  = msb_q ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
    assign cnt_d       = cnt_q + 1'b1;

    // Ready while idle, or in the cycle the last bit is being consumed so the
    // next word can be loaded without an idle gap.
    assign ser_ready = (state_q == IDLE) ||
                       ((state_q == ACTIVE) && last_bit && ser_en);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            data_q  <= IDLE_VAL;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Data_Valid) begin
                        state_q <= ACTIVE;
                        shreg_q <= P_DATA;
                        msb_q   <= msb_first;
                        cnt_q   <= '0;
                        data_q  <= first_bit_d;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ser_en) begin
                        if (!last_bit) begin
                            cnt_q   <= cnt_d;
                            shreg_q <= shreg_d;
                            data_q  <= next_bit_d;
                            done_q  <= (cnt_d == LAST_IDX);
                        end else if (Data_Valid) begin
                            // Back-to-back reload without leaving ACTIVE.
                            shreg_q <= P_DATA;
                            msb_q   <= msb_first;
                            cnt_q   <= '0;
                            data_q  <= first_bit_d;
                            done_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            data_q  <= IDLE_VAL;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    data_q  <= IDLE_VAL;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ser_data = data_q;
    assign ser_done = done_q;
    assign ser_busy = busy_q;

endmodule
